// File: rtl/spm_product_deser.sv
`default_nettype none
// ============================================================================
//  Module   : spm_product_deser
//  Purpose  : Receiving end of the serial-parallel multiplier product stream.
//             Aligns to a start pulse, shifts in exactly XW+YW product bits
//             (LSB first) and presents the assembled word on a valid/ready
//             handshake.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous reset, active low
//             start      - one-cycle pulse, first y bit entering the spm
//             p          - serial product bit
//             prod       - assembled product (meaningful while prod_valid)
//             prod_valid - prod complete and held
//             prod_ready - consumer accepts prod
//             busy       - collection in progress
//             overrun    - sticky: a start was dropped
//             clr_ovr    - synchronous clear of overrun
//  Revision : 1.0  initial release
// ============================================================================
module spm_product_deser #(
    parameter int XW  = 32,
    parameter int YW  = 32,
    parameter int LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p,
    output logic [XW+YW-1:0]   prod,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic               busy,
    output logic               overrun,
    input  logic               clr_ovr
);

    localparam int         PW       = XW + YW;
    localparam int         CW       = $clog2(PW + 1);
    localparam logic [3:0] C_LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_sr;
    logic [PW-1:0]   w_sr_nxt;
    logic [PW-1:0]   w_shifted;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      r_lat;
    logic [3:0]      w_lat_nxt;
    logic            r_valid;
    logic            r_busy;
    logic            r_ovr;
    logic            w_launch;
    logic            w_capture0;
    logic            w_drop;

    // New bits enter at the top so that after PW shifts the first bit
    // received sits in bit 0.
    assign w_shifted = {p, r_sr[PW-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_lat_nxt   = r_lat;
        w_launch    = 1'b0;
        w_capture0  = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_launch = start;
            end
            ST_WAIT: begin
                // The cycle in which the latency counter has reached zero is
                // the cycle product bit 0 is on p, so it is captured here.
                if (r_lat == 4'd0) begin
                    w_capture0 = 1'b1;
                end else begin
                    w_lat_nxt = r_lat - 4'd1;
                end
                w_drop = start;
            end
            ST_SHIFT: begin
                w_sr_nxt  = w_shifted;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(PW - 1)) begin
                    w_state_nxt = ST_HOLD;
                end
                w_drop = start;
            end
            ST_HOLD: begin
                if (prod_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_launch    = start;
                end else begin
                    w_drop = start;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_launch) begin
            if (LAT == 0) begin
                w_capture0 = 1'b1;
            end else begin
                w_state_nxt = ST_WAIT;
                w_lat_nxt   = C_LAT_M1;
            end
        end

        if (w_capture0) begin
            w_sr_nxt    = w_shifted;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_SHIFT;
        end
    end

    // Flag outputs are flopped from the next state so they stay registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_lat   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lat   <= w_lat_nxt;
            r_valid <= (w_state_nxt == ST_HOLD);
            r_busy  <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_SHIFT);
            // A dropped start wins over a coincident clear.
            r_ovr   <= w_drop | (r_ovr & ~clr_ovr);
        end
    end

    assign prod       = r_sr;
    assign prod_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: doc/spm_product_deser.md
# spm_product_deser

Serial-to-parallel collector for the product stream of the serial-parallel multiplier (spm). The spm emits its product one bit per clock, LSB first, while its serial `y` operand is shifted in. This block is the receiving end of that stream. It aligns to a start pulse, absorbs exactly `XW+YW` product bits and presents the assembled word on a valid/ready handshake to the downstream parallel consumer.

## Interface
Parameters:
- `XW`, default 32: width of the parallel multiplicand `x`.
- `YW`, default 32: width of the serial multiplier `y`.
- `LAT`, default 1: cycles from the `start` pulse to product bit 0 appearing on `p`. Legal range is 0..15.

Derived:
- `PW = XW+YW`: product width.
- `CW = $clog2(PW+1)`: bit counter width.

Ports:
- `clk`  in  1  the single clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse, coincident with the cycle the first `y` bit enters the spm.
- `p`  in  1  serial product bit from the spm.
- `prod`  out  PW  assembled product.
- `prod_valid`  out  1  `prod` is complete and held.
- `prod_ready`  in  1  consumer accepts `prod`.
- `busy`  out  1  a collection is in progress (state WAIT or SHIFT).
- `overrun`  out  1  sticky flag: a `start` was dropped.
- `clr_ovr`  in  1  synchronous clear of `overrun`.

## Operation
States: IDLE, WAIT, SHIFT, HOLD.

- **IDLE**
  - `start`=1 and `LAT`=0: go to SHIFT. Bit 0 is captured in this same cycle (`p` sampled with `start`), and the counter is loaded with 1.
  - `start`=1 and `LAT`>0: go to WAIT, with the latency counter loaded with `LAT-1`.
- **WAIT**
  - Decrement the latency counter each cycle.
  - When it reaches 0, go to SHIFT. The next cycle samples bit 0.
- **SHIFT**
  - Each cycle: `sr <= {p, sr[PW-1:1]}` and `cnt <= cnt+1`.
  - On the cycle that captures bit `PW-1` (`cnt`==`PW-1`): go to HOLD, with `prod_valid` set from the next cycle.
- **HOLD**
  - `prod` and `prod_valid` are stable until `prod_valid && prod_ready`.
  - On acceptance:
    - `start` in the same cycle: go straight to WAIT or SHIFT (per `LAT`, same rules as IDLE). The new stream is not counted as an overrun.
    - Otherwise: go to IDLE.
- **Dropped start:** `start` in WAIT, SHIFT, or HOLD-without-acceptance sets `overrun`. The current collection is unaffected.
- **`overrun` clear:** `clr_ovr` clears `overrun`. If it coincides with a dropped `start`, the flag stays set (set wins).
- **`prod` register:**
  - It is the shift register itself. Its value is undefined-but-deterministic outside HOLD.
  - The consumer uses it only while `prod_valid`=1.
- **No arithmetic:** `p` is never inspected. Bit order is preserved exactly, so `prod[i]` is the i-th bit received.

## Timing
- **Reset values** (asynchronous, on `rst`=0): state IDLE, `prod`=0, `prod_valid`=0, `busy`=0, `overrun`=0, all counters 0.
- **Reset mid-collection:** abandons the word. No `prod_valid` is produced for it.
- **Latency:** `prod_valid` rises exactly `LAT+PW` cycles after the `start` cycle.
- **Outputs:** all outputs are registered. There is no combinational path from `prod_ready` or `start` to any output.
- **Throughput:** with `prod_ready` tied high and `start` re-issued on the acceptance cycle, one product is delivered every `LAT+PW` cycles with zero bubble.
- **Backpressure:** `prod_ready` deasserted holds HOLD indefinitely. The spm stream is not stalled, so any `start` issued during backpressure is dropped and flagged.
- **`prod_ready` outside HOLD:** ignored.

## Test plan
Scenarios 1–4 use `XW`=`YW`=4 (`PW`=8).

1. **Single product, `LAT`=1.**
   - Stimulus: `start` at cycle 0; `p` bits 1,1,1,1,0,0,0,1 on cycles 1..8 (0xB×0xD=0x8F); `prod_ready`=1.
   - Required: `prod_valid` high at cycle 9 only, with `prod`=0x8F; `busy` high on cycles 1..8.
2. **Backpressure.**
   - Stimulus: as scenario 1, but `prod_ready`=0 until cycle 14; a second `start` at cycle 11.
   - Required: `prod`=0x8F and `prod_valid` held on cycles 9..14; `overrun`=1 from cycle 12; IDLE at cycle 15.
3. **Back-to-back, `LAT`=0.**
   - Stimulus: `start` at cycle 0 with stream 0x8F; `start` again on the acceptance cycle with stream 0x00.
   - Required: `prod_valid` at cycle 8 (0x8F) and at cycle 16 (0x00); `overrun` stays 0.
4. **Reset mid-operation.**
   - Stimulus: `rst` low during cycle 5 of a collection; then a fresh `start` with stream 0xFF.
   - Required: all outputs 0 immediately; next `prod`=0xFF with no residue from the aborted word.
5. **Overrun clear precedence.**
   - Stimulus: `clr_ovr` and a dropped `start` in the same cycle.
   - Required: `overrun` stays 1. `clr_ovr` alone on the next cycle clears it to 0.
6. **Default widths (`PW`=64, `LAT`=3).**
   - Stimulus: alternating stream 1,0,1,0…
   - Required: `prod`=0x5555_5555_5555_5555 at cycle 67.
